store_write_buffer: RTL and testbench
=====================================

Name: store_write_buffer

Overview:
- Posted-write store buffer between the store data shifter (MEM stage) and the data-memory bus.
- Accepts already lane-shifted store data plus the SB/SH/SW size flags, derives 4-bit byte write strobes, and queues entries in an in-order FIFO.
- Drains the FIFO over a req/ack bus.
- Flags loads that hit a pending store word so the pipeline can stall them.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, >= 2
ADDR_W, 32, byte address width

Ports:
clk  input  1  system clock, all state on rising edge
resetn  input  1  synchronous active-low reset
st_valid  input  1  store request from MEM stage
st_ready  output  1  buffer can accept a store this cycle
st_addr  input  ADDR_W  store byte address
st_data  input  32  store data, already shifted into byte lanes
st_sb  input  1  store byte
st_sh  input  1  store halfword
mem_req  output  1  bus write request (head entry valid)
mem_addr  output  ADDR_W  word-aligned write address, bits [1:0] = 0
mem_wdata  output  32  write data
mem_wstrb  output  4  byte write strobes, bit i = byte lane i
mem_ack  input  1  bus accepted the current write
ld_check  input  1  a load in MEM wants a hazard check
ld_addr  input  ADDR_W  load byte address
ld_conflict  output  1  load word matches a pending or incoming store
empty  output  1  FIFO holds no entries
count  output  log2(DEPTH)+1  number of valid entries

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on resetn.
- Reset state (rising edge with resetn = 0):
  - wr_ptr = rd_ptr = 0, count = 0, all entries invalid.
  - Resulting outputs: mem_req = 0, empty = 1, ld_conflict = 0.
  - While resetn = 0, st_ready is forced to 0 combinationally.
  - Reset mid-drain discards all queued entries; no ack is awaited.
- Strobe generation at push, priority SB > SH > word:
  - SB: 4'b0001 << st_addr[1:0].
  - SH: st_addr[1] ? 4'b1100 : 4'b0011.
  - Otherwise: 4'b1111.
- Alignment faults are handled upstream; st_addr[0] is ignored for SH, and st_addr[1:0] is ignored for word stores.
- Stored address is {st_addr[ADDR_W-1:2], 2'b00}. Data is stored unmodified; non-strobed lanes are don't-care to the bus.
- Push:
  - st_ready = resetn & (count != DEPTH).
  - Push on st_valid & st_ready, writing entry[wr_ptr], then wr_ptr increments and wraps modulo DEPTH.
  - No push-when-full bypass: a full FIFO deasserts st_ready even if a pop occurs that cycle.
- Drain:
  - mem_req = (count != 0). mem_addr, mem_wdata and mem_wstrb are driven combinationally from entry[rd_ptr].
  - These must stay stable while mem_req = 1 and mem_ack = 0.
  - Pop on mem_req & mem_ack, then rd_ptr increments and wraps.
  - mem_ack with mem_req = 0 is ignored.
- Latency: a store pushed into an empty buffer appears on mem_req in the next cycle (no combinational bypass). Back-to-back acks drain one entry per cycle.
- Count update:
  - push only: +1; pop only: -1; push and pop in the same cycle: count unchanged, both pointers advance.
  - empty = (count == 0).
- Ordering: strictly FIFO; writes reach the bus in acceptance order.
- ld_conflict (combinational) = ld_check & (any valid entry OR the store being pushed this cycle) has word address [ADDR_W-1:2] equal to ld_addr[ADDR_W-1:2].
  - The comparison is conservative: byte strobes are ignored.
  - The entry being popped this cycle still counts.
- Overflow and underflow cannot occur by construction. count never exceeds DEPTH and never drops below 0.

Test Plan:
- Reset: hold resetn = 0 for 2 cycles with st_valid = 1 -> st_ready = 0, mem_req = 0, empty = 1, count = 0; release -> st_ready = 1.
- Strobes: push SB at 0x1003, SH at 0x2002, SW at 0x3000 with mem_ack held 1 -> bus sees (0x1000, 4'b1000), (0x2000, 4'b1100), (0x3000, 4'b1111) on consecutive cycles. First write appears 1 cycle after the first push.
- Full/backpressure:
  - With mem_ack = 0, push 4 stores -> count = 4, st_ready = 0, and a 5th st_valid is not accepted.
  - mem_addr stays at entry 0 for 10 cycles.
  - Pulse mem_ack once -> count = 3, st_ready = 1.
- Simultaneous push/pop:
  - With count = 2, assert st_valid and mem_ack in the same cycle -> count stays 2.
  - Pointer wrap check: push 9 total stores with intermittent acks -> all 9 reach the bus in order with correct data.
- Load hazard:
  - Pending SB at 0x4001; ld_check with ld_addr = 0x4002 -> ld_conflict = 1.
  - ld_addr = 0x4004 -> ld_conflict = 0.
  - Incoming-store check: with the buffer empty, a push to 0x5000 in the same cycle as ld_addr = 0x5003 -> ld_conflict = 1.
- Reset mid-drain: 3 entries queued, mem_ack = 0, assert resetn = 0 for 1 cycle -> next cycle count = 0, mem_req = 0; a following push issues normally.

Source files
------------

// File: rtl/store_write_buffer.sv
// Posted-write store buffer: queues lane-shifted stores with byte strobes in an
// in-order FIFO, drains them over a req/ack bus and flags loads to pending words.
module store_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [31:0]              st_data,
    input  logic                     st_sb,
    input  logic                     st_sh,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_wstrb,
    input  logic                     mem_ack,
    input  logic                     ld_check,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_conflict,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_W - 2;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [DEPTH-1:0] r_valid;

    // Entry payload carries no reset: r_valid alone decides what is live.
    logic [WA_W-1:0]  r_waddr [DEPTH];
    logic [31:0]      r_data  [DEPTH];
    logic [3:0]       r_strb  [DEPTH];

    logic             w_push;
    logic             w_pop;
    logic [3:0]       w_strb;
    logic [DEPTH-1:0] w_hit;
    logic             w_incoming_hit;
    logic             w_unused_ok;

    assign w_unused_ok = &{1'b0, ld_addr[1:0]};

    assign st_ready = resetn & (r_count != DEPTH_C);
    assign mem_req  = (r_count != '0);
    assign empty    = (r_count == '0);
    assign count    = r_count;

    assign w_push = st_valid & st_ready;
    assign w_pop  = mem_req & mem_ack;

    always_comb begin
        w_strb = 4'b1111;
        if (st_sb) begin
            w_strb = 4'b0001 << st_addr[1:0];
        end else if (st_sh) begin
            w_strb = st_addr[1] ? 4'b1100 : 4'b0011;
        end
    end

    assign mem_addr  = {r_waddr[r_rd_ptr], 2'b00};
    assign mem_wdata = r_data[r_rd_ptr];
    assign mem_wstrb = r_strb[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_waddr[r_wr_ptr] <= st_addr[ADDR_W-1:2];
            r_data[r_wr_ptr]  <= st_data;
            r_strb[r_wr_ptr]  <= w_strb;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A push and a pop never target the same slot: push needs a free slot,
    // pop needs an occupied one.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (r_wr_ptr == PTR_W'(i))) begin
                    r_valid[i] <= 1'b1;
                end else if (w_pop && (r_rd_ptr == PTR_W'(i))) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Word-granular hazard compare; strobes are ignored on purpose.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign w_hit[gi] = r_valid[gi] & (r_waddr[gi] == ld_addr[ADDR_W-1:2]);
        end
    endgenerate

    assign w_incoming_hit = w_push & (st_addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]);
    assign ld_conflict    = ld_check & ((|w_hit) | w_incoming_hit);

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: a scoreboard queue holds expected bus
// writes, pushed as stores are accepted and popped as the bus acknowledges.
module tb_store_write_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              resetn;
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic              st_sb;
    logic              st_sh;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ack;
    logic              ld_check;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_conflict;
    logic              empty;
    logic [2:0]        count;

    store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_sb       (st_sb),
        .st_sh       (st_sh),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_ack     (mem_ack),
        .ld_check    (ld_check),
        .ld_addr     (ld_addr),
        .ld_conflict (ld_conflict),
        .empty       (empty),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } exp_t;

    exp_t sb[$];
    exp_t cur_exp;
    int   errors = 0;
    int   checks = 0;
    int   m_count = 0;
    logic exp_conflict = 1'b0;
    logic last_push = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] addr, input logic [31:0] data,
                         input logic sbf, input logic shf, input logic [3:0] strb);
        st_valid     = 1'b1;
        st_addr      = addr;
        st_data      = data;
        st_sb        = sbf;
        st_sh        = shf;
        cur_exp.addr = {addr[31:2], 2'b00};
        cur_exp.data = data;
        cur_exp.strb = strb;
    endtask

    // One clock: check outputs mid-cycle, update scoreboard and count model,
    // then advance past the rising edge.
    task automatic step();
        logic exp_ready;
        logic pop;
        exp_t head;
        @(negedge clk);
        exp_ready = resetn && (m_count != DEPTH);
        chk("st_ready", 32'(st_ready), 32'(exp_ready));
        chk("mem_req", 32'(mem_req), 32'(m_count != 0));
        chk("empty", 32'(empty), 32'(m_count == 0));
        chk("count", 32'(count), 32'(m_count));
        chk("ld_conflict", 32'(ld_conflict), 32'(exp_conflict));
        pop = (m_count != 0) && mem_ack;
        if (m_count != 0 && sb.size() > 0) begin
            head = sb[0];
            chk("mem_addr", mem_addr, head.addr);
            chk("mem_wdata", mem_wdata, head.data);
            chk("mem_wstrb", 32'(mem_wstrb), 32'(head.strb));
            if (pop) begin
                $display("bus write addr=%08h data=%08h strb=%04b", mem_addr, mem_wdata, mem_wstrb);
                void'(sb.pop_front());
            end
        end
        last_push = st_valid && exp_ready;
        if (last_push) begin
            sb.push_back(cur_exp);
            $display("store accepted addr=%08h data=%08h strb=%04b", st_addr, st_data, cur_exp.strb);
        end
        @(posedge clk);
        #1;
        if (!resetn) begin
            m_count = 0;
            sb.delete();
        end else begin
            m_count = m_count + (last_push ? 1 : 0) - (pop ? 1 : 0);
        end
    endtask

    initial begin
        int n;
        int guard;
        resetn   = 1'b0;
        st_valid = 1'b1;
        st_addr  = '0;
        st_data  = '0;
        st_sb    = 1'b0;
        st_sh    = 1'b0;
        mem_ack  = 1'b0;
        ld_check = 1'b0;
        ld_addr  = '0;
        cur_exp  = '0;

        // Reset held two cycles with st_valid asserted
        @(posedge clk);
        #1;
        step();
        resetn   = 1'b1;
        st_valid = 1'b0;
        step();

        // Strobe generation with the bus always accepting
        mem_ack = 1'b1;
        drive(32'h0000_1003, 32'hAA00_0000, 1'b1, 1'b0, 4'b1000); step();
        drive(32'h0000_2002, 32'hBBBB_0000, 1'b0, 1'b1, 4'b1100); step();
        drive(32'h0000_3000, 32'h1234_5678, 1'b0, 1'b0, 4'b1111); step();
        drive(32'h0000_6001, 32'h0000_CCCC, 1'b0, 1'b1, 4'b0011); step();
        drive(32'h0000_7003, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'b1111); step();
        drive(32'h0000_8002, 32'h00DD_0000, 1'b1, 1'b1, 4'b0100); step();
        st_valid = 1'b0;
        step();
        step();

        // Fill to full with the bus stalled, then offer a fifth store
        mem_ack = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(32'h0000_9000 + 32'(i * 4), 32'h1111_0000 + 32'(i), 1'b0, 1'b0, 4'b1111);
            step();
        end
        drive(32'h0000_9F00, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'b1111);
        step();
        chk("full_count", 32'(count), 32'd4);
        st_valid = 1'b0;
        repeat (10) step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        chk("after_pulse_count", 32'(count), 32'd3);
        chk("after_pulse_ready", 32'(st_ready), 32'd1);

        // Push and pop in the same cycle at count 2
        mem_ack = 1'b1;
        step();
        drive(32'h0000_9100, 32'h2222_2222, 1'b0, 1'b0, 4'b1111);
        step();
        chk("push_pop_count", 32'(count), 32'd2);
        st_valid = 1'b0;
        repeat (4) step();

        // Nine stores with random acks to exercise pointer wrap
        n = 0;
        guard = 0;
        while (n < 9 && guard < 200) begin
            drive(32'h0000_A000 + 32'(n * 16), $urandom, 1'b0, 1'b0, 4'b1111);
            mem_ack = 1'($urandom_range(0, 1));
            step();
            if (last_push) n++;
            guard++;
        end
        chk("wrap_accepted", 32'(n), 32'd9);
        st_valid = 1'b0;
        mem_ack  = 1'b1;
        repeat (DEPTH + 2) step();
        chk("wrap_empty", 32'(empty), 32'd1);

        // Load hazard against a pending byte store
        mem_ack = 1'b0;
        drive(32'h0000_4001, 32'h0000_5500, 1'b1, 1'b0, 4'b0010);
        step();
        st_valid     = 1'b0;
        ld_check     = 1'b1;
        ld_addr      = 32'h0000_4002;
        exp_conflict = 1'b1;
        step();
        ld_addr      = 32'h0000_4004;
        exp_conflict = 1'b0;
        step();
        ld_check = 1'b0;
        mem_ack  = 1'b1;
        step();
        step();

        // Hazard against the store entering an empty buffer this cycle
        mem_ack = 1'b0;
        drive(32'h0000_5000, 32'h5050_5050, 1'b0, 1'b0, 4'b1111);
        ld_check     = 1'b1;
        ld_addr      = 32'h0000_5003;
        exp_conflict = 1'b1;
        step();
        st_valid     = 1'b0;
        ld_check     = 1'b0;
        exp_conflict = 1'b0;
        mem_ack      = 1'b1;
        step();
        step();

        // Reset while three entries wait on a stalled bus
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'h0000_C000 + 32'(i * 4), 32'h3333_0000 + 32'(i), 1'b0, 1'b0, 4'b1111);
            step();
        end
        st_valid = 1'b0;
        resetn   = 1'b0;
        step();
        resetn = 1'b1;
        step();
        chk("reset_drain_count", 32'(count), 32'd0);
        drive(32'h0000_B002, 32'h7777_0000, 1'b0, 1'b1, 4'b1100);
        step();
        st_valid = 1'b0;
        step();
        mem_ack = 1'b1;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
